// File: rtl/adpll_gain_scheduler_if.sv
// adpll_gain_scheduler_if: control bus between the ADPLL lock controller (slave) and its environment (master): start/early/loop_ovf in, gains/sel/state/locked/relock_count out
interface adpll_gain_scheduler_if;
  logic       start;
  logic       early;
  logic       loop_ovf;
  logic [1:0] sel;
  logic [4:0] plusInt;
  logic [4:0] minusInt;
  logic [4:0] plusProp;
  logic [4:0] plusPropDiff;
  logic [4:0] minusProp;
  logic [4:0] minusPropDiff;
  logic [1:0] state;
  logic       locked;
  logic [3:0] relock_count;
  modport master (
    output start, early, loop_ovf,
    input  sel, plusInt, minusInt, plusProp, plusPropDiff, minusProp, minusPropDiff,
    input  state, locked, relock_count
  );
  modport slave (
    input  start, early, loop_ovf,
    output sel, plusInt, minusInt, plusProp, plusPropDiff, minusProp, minusPropDiff,
    output state, locked, relock_count
  );
endinterface

// File: rtl/adpll_gain_scheduler.sv
// adpll_gain_scheduler: sequences PID filter gains COARSE->FINE->TRACK from early-toggle lock detection; ports clk, reset (sync, high), bus (slave: start/early/loop_ovf in; sel, int/prop gains, state, locked, relock_count out)
module adpll_gain_scheduler #(
  parameter int unsigned ACQ_CYCLES   = 16,
  parameter int unsigned LOCK_WINDOW  = 8,
  parameter int unsigned LOCK_TOGGLES = 4,
  parameter int unsigned KI_C         = 8,
  parameter int unsigned KI_F         = 4,
  parameter int unsigned KI_T         = 1,
  parameter int unsigned KP_C         = 16,
  parameter int unsigned KP_F         = 8,
  parameter int unsigned KP_T         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  adpll_gain_scheduler_if.slave  bus
);
  localparam int WW = LOCK_WINDOW > 1 ? $clog2(LOCK_WINDOW) : 1;
  localparam int TW = $clog2(LOCK_WINDOW + 1);
  localparam int AW = $clog2(ACQ_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, COARSE = 2'd1, FINE = 2'd2, TRACK = 2'd3} state_t;
  state_t        state_q, state_d;
  logic          early_q;
  logic [WW-1:0] win_q, win_d;
  logic [TW-1:0] tog_q, tog_d, tog_sum;
  logic [AW-1:0] acq_q, acq_d, acq_inc;
  logic          bal_q, bal_d;
  logic [3:0]    relock_q, relock_d;
  logic [1:0]    sel_q, sel_d;
  logic [4:0]    ki_d, kp_d, ki_q, nki_q, kp_q, kpd_q;
  logic          locked_q;
  logic          toggle, win_end, balanced, entry;
  always_comb begin
    toggle   = bus.early ^ early_q;
    win_end  = win_q == WW'(LOCK_WINDOW - 1);
    tog_sum  = &tog_q ? tog_q : tog_q + TW'(toggle);
    balanced = 32'(tog_sum) >= LOCK_TOGGLES;
    acq_inc  = acq_q == AW'(ACQ_CYCLES) ? acq_q : acq_q + AW'(1);
    state_d  = state_q;
    bal_d    = bal_q;
    relock_d = relock_q;
    if (!bus.start) state_d = IDLE;
    else begin
      case (state_q)
        COARSE: if (win_end && balanced && 32'(acq_inc) >= ACQ_CYCLES) state_d = FINE;
        FINE: begin
          if (bus.loop_ovf) state_d = COARSE;
          else if (win_end) begin
            bal_d = balanced;
            if (balanced && bal_q) state_d = TRACK;
          end
        end
        TRACK: begin
          if (bus.loop_ovf || (win_end && !balanced)) begin
            state_d  = COARSE;
            relock_d = &relock_q ? relock_q : relock_q + 4'd1;
          end
        end
        default: state_d = COARSE;
      endcase
    end
    entry = state_d != state_q;
    bal_d = entry ? 1'b0 : bal_d;
    win_d = (entry || win_end) ? '0 : win_q + WW'(1);
    tog_d = (entry || win_end) ? '0 : tog_sum;
    acq_d = entry ? '0 : (state_q == COARSE) ? acq_inc : acq_q;
    ki_d  = state_d == COARSE ? 5'(KI_C) : state_d == FINE ? 5'(KI_F) : state_d == TRACK ? 5'(KI_T) : 5'd0;
    kp_d  = state_d == COARSE ? 5'(KP_C) : state_d == FINE ? 5'(KP_F) : state_d == TRACK ? 5'(KP_T) : 5'd0;
    sel_d = state_d == IDLE ? 2'b00 : {~bus.early, toggle};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      early_q  <= 1'b0;
      win_q    <= '0;
      tog_q    <= '0;
      acq_q    <= '0;
      bal_q    <= 1'b0;
      relock_q <= 4'd0;
      sel_q    <= 2'b00;
      ki_q     <= 5'd0;
      nki_q    <= 5'd0;
      kp_q     <= 5'd0;
      kpd_q    <= 5'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      early_q  <= bus.early;
      win_q    <= win_d;
      tog_q    <= tog_d;
      acq_q    <= acq_d;
      bal_q    <= bal_d;
      relock_q <= relock_d;
      sel_q    <= sel_d;
      ki_q     <= ki_d;
      nki_q    <= 5'd0 - ki_d;
      kp_q     <= kp_d;
      kpd_q    <= kp_d >> 1;
      locked_q <= state_d == TRACK;
    end
  end
  assign bus.state         = state_q;
  assign bus.locked        = locked_q;
  assign bus.relock_count  = relock_q;
  assign bus.sel           = sel_q;
  assign bus.plusInt       = ki_q;
  assign bus.minusInt      = nki_q;
  assign bus.plusProp      = kp_q;
  assign bus.minusProp     = kp_q;
  assign bus.plusPropDiff  = kpd_q;
  assign bus.minusPropDiff = kpd_q;
endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// tb_adpll_gain_scheduler: directed self-checking bench for adpll_gain_scheduler
module tb_adpll_gain_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  adpll_gain_scheduler_if bus();
  adpll_gain_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [29:0] gains_of(input int s);
    case (s)
      1:       return {5'd8, 5'b11000, 5'd16, 5'd8, 5'd16, 5'd8};
      2:       return {5'd4, 5'b11100, 5'd8, 5'd4, 5'd8, 5'd4};
      3:       return {5'd1, 5'b11111, 5'd2, 5'd1, 5'd2, 5'd1};
      default: return 30'd0;
    endcase
  endfunction
  task automatic check_phase(input string tag, input int s);
    check({tag, "_state"}, 32'(bus.state), 32'(s));
    check({tag, "_locked"}, 32'(bus.locked), 32'(s == 3));
    check({tag, "_gains"}, 32'({bus.plusInt, bus.minusInt, bus.plusProp, bus.plusPropDiff, bus.minusProp, bus.minusPropDiff}), 32'(gains_of(s)));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alt();
    bus.early = ~bus.early;
    tick();
  endtask
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic acquire(input string tag);
    for (int i = 0; i < 15; i++) begin
      bus.loop_ovf = (i == 4);
      alt();
    end
    bus.loop_ovf = 1'b0;
    check_phase({tag, "_coarse"}, 1);
    alt();
    check_phase({tag, "_fine"}, 2);
    for (int i = 0; i < 15; i++) alt();
    check_phase({tag, "_fine_end"}, 2);
    alt();
    check_phase({tag, "_track"}, 3);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.early = 1'b0;
    bus.loop_ovf = 1'b0;
    alt();
    alt();
    check_phase("reset", 0);
    check("reset_relock", 32'(bus.relock_count), 32'd0);
    check("reset_sel", 32'(bus.sel), 32'd0);
    reset = 1'b0;
    alt();
    check_phase("start", 1);
    check("start_sel", 32'(bus.sel), 32'd1);
    acquire("acq0");
    check("acq0_relock", 32'(bus.relock_count), 32'd0);
    hold(7);
    check_phase("ovf_win_pre", 3);
    bus.loop_ovf = 1'b1;
    tick();
    bus.loop_ovf = 1'b0;
    check_phase("ovf_win", 1);
    check("ovf_win_relock", 32'(bus.relock_count), 32'd1);
    acquire("acq1");
    bus.loop_ovf = 1'b1;
    alt();
    bus.loop_ovf = 1'b0;
    check_phase("ovf_track", 1);
    check("ovf_track_relock", 32'(bus.relock_count), 32'd2);
    for (int i = 0; i < 16; i++) alt();
    check_phase("fine_ovf_pre", 2);
    hold(0);
    alt();
    alt();
    alt();
    bus.loop_ovf = 1'b1;
    alt();
    bus.loop_ovf = 1'b0;
    check_phase("fine_ovf", 1);
    check("fine_ovf_relock", 32'(bus.relock_count), 32'd2);
    for (int i = 0; i < 16; i++) alt();
    check_phase("stop_pre", 2);
    alt();
    alt();
    alt();
    bus.start = 1'b0;
    alt();
    check_phase("stop", 0);
    check("stop_sel", 32'(bus.sel), 32'd0);
    check("stop_relock", 32'(bus.relock_count), 32'd2);
    alt();
    check_phase("stop_hold", 0);
    bus.start = 1'b1;
    alt();
    check_phase("restart", 1);
    acquire("acq2");
    for (int i = 1; i <= 20; i++) begin
      hold(7);
      check_phase($sformatf("loss%0d_pre", i), 3);
      tick();
      check_phase($sformatf("loss%0d", i), 1);
      check($sformatf("loss%0d_relock", i), 32'(bus.relock_count), 32'((i + 2) > 15 ? 15 : i + 2));
      if (i < 20) acquire($sformatf("reacq%0d", i));
    end
    reset = 1'b1;
    bus.early = 1'b1;
    tick();
    tick();
    check_phase("reset2", 0);
    check("reset2_relock", 32'(bus.relock_count), 32'd0);
    reset = 1'b0;
    bus.early = 1'b1;
    tick();
    check("sel0", 32'(bus.sel), 32'd1);
    check_phase("sel_coarse", 1);
    bus.early = 1'b1;
    tick();
    check("sel1", 32'(bus.sel), 32'd0);
    bus.early = 1'b0;
    tick();
    check("sel2", 32'(bus.sel), 32'd3);
    bus.early = 1'b0;
    tick();
    check("sel3", 32'(bus.sel), 32'd2);
    bus.early = 1'b1;
    tick();
    check("sel4", 32'(bus.sel), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adpll_gain_scheduler.md
# adpll_gain_scheduler

Lock-acquisition controller for the ADPLL PID loop filter. It sequences the filter through coarse, fine and tracking gain phases. In each phase it drives the filter's integral and proportional gain inputs and its proportional-path `sel` from the PFD `early` history. It detects lock and loss of lock by counting `early` toggles per observation window, and restarts acquisition on loss of lock or on filter overflow.

## Interface
Parameters:
- `ACQ_CYCLES`, 16: minimum cycles spent in COARSE.
- `LOCK_WINDOW`, 8: observation window length, in cycles.
- `LOCK_TOGGLES`, 4: minimum `early` toggles per window for a window to count as balanced.
- `KI_C` / `KI_F` / `KI_T`, 8 / 4 / 1: integral gain for COARSE / FINE / TRACK. Legal range 1..15.
- `KP_C` / `KP_F` / `KP_T`, 16 / 8 / 2: proportional gain for COARSE / FINE / TRACK. Legal range 0..31.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level enable; low forces IDLE.
- `early`  in  1  PFD early/late decision.
- `loop_ovf`  in  1  filter integrator overflow flag.
- `sel`  out  2  proportional-path select to the filter.
- `plusInt`, `minusInt`  out  5  signed integral gains.
- `plusProp`, `plusPropDiff`, `minusProp`, `minusPropDiff`  out  5  proportional gains.
- `state`  out  2  IDLE=0, COARSE=1, FINE=2, TRACK=3.
- `locked`  out  1  high iff `state`==TRACK.
- `relock_count`  out  4  number of lock losses, saturating.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, every gain output 0, `sel`=0, `locked`=0, `relock_count`=0. Internal `early_q`, window counter, toggle counter and acquisition counter are all cleared to 0.
- Toggle: a toggle is any cycle with `early`!=`early_q`. The toggle counter saturates at its maximum value.
- Window counter: counts 0..`LOCK_WINDOW`-1. On the cycle it wraps, the window is evaluated:
  - balanced if toggles ≥ `LOCK_TOGGLES`;
  - the toggle counter then clears.
- State entry: on entering any state, the window, toggle and acquisition counters restart from 0.
- IDLE: all gains 0 and `sel`=0. Transition to COARSE when `start`=1.
- COARSE: the acquisition counter increments each cycle and saturates at `ACQ_CYCLES`. Transition to FINE at a window end that is balanced and has the acquisition count ≥ `ACQ_CYCLES`.
- FINE: transition to TRACK after two consecutive balanced windows. An unbalanced window resets the consecutive count to 0.
- TRACK:
  - on an unbalanced window end, or on `loop_ovf`=1, go to COARSE and increment `relock_count` by exactly one, even if both events occur in the same cycle;
  - `relock_count` saturates at 15.
- FINE on `loop_ovf`: go to COARSE; `relock_count` is not incremented.
- Priority: `reset` > `start`=0 (go to IDLE from any state) > `loop_ovf` > window evaluation.
- Gain mapping for phase X ∈ {C, F, T}:
  - `plusInt` = +KI_X; `minusInt` = −KI_X as 5-bit two's complement (for example KI=8 gives 5'b11000);
  - `plusProp` = `minusProp` = KP_X;
  - `plusPropDiff` = `minusPropDiff` = KP_X>>1.
- `sel` in non-IDLE states: `sel` <= {~`early`, `early`^`early_q`}. That is:
  - early and steady gives 0;
  - early and just changed gives 1;
  - late and steady gives 2;
  - late and just changed gives 3.

## Timing
- `state` and the gain outputs change together, one cycle after the transition condition is sampled.
- `locked` is high in the same cycle that `state` reads TRACK.
- `sel` reflects `early` sampled on the previous edge (1-cycle latency). `sel` is 0 in the cycle IDLE is entered.
- With `early` toggling every cycle from the first cycle:
  - COARSE lasts exactly `ACQ_CYCLES` cycles, rounded up to a window multiple;
  - FINE lasts exactly 2×`LOCK_WINDOW` cycles.
- `reset` or `start`=0 mid-acquisition takes effect at the next edge. Gains are 0 in the following cycle and no relock is counted.
- `loop_ovf` asserted in IDLE or COARSE is ignored.

## Test plan
All scenarios use the default parameters.
1. Assert `reset` for 2 cycles with `start`=1 and `early` toggling → `state`=0, all gain outputs 0, `locked`=0, `relock_count`=0.
2. Release reset, `start`=1, `early` alternating every cycle → COARSE with `plusInt`=8, `minusInt`=5'b11000, `plusProp`=16, `plusPropDiff`=8 for 16 cycles; then FINE (`plusInt`=4, `minusInt`=5'b11100, `plusProp`=8) for 16 cycles; then TRACK (`plusInt`=1, `plusProp`=2, `plusPropDiff`=1) with `locked`=1.
3. In TRACK, hold `early`=1 for 8 cycles → at the window end `state`=COARSE, `locked`=0, `relock_count`=1. Repeat 20 times → `relock_count` holds at 15.
4. In TRACK, pulse `loop_ovf` for 1 cycle coinciding with an unbalanced window end → COARSE on the next cycle and `relock_count` increments by exactly 1.
5. In COARSE, drive `early` = 1,1,0,0,1 → `sel` sequence (each value one cycle after its `early` sample): 1 (from `early_q`=0 after reset), 0, 3, 2, 1.
6. Drop `start` to 0 mid-FINE, then raise it again → IDLE with gains 0 on the next cycle, then a COARSE restart with full counter reset (16 more cycles before FINE).
